binary_to_decimal_serial: RTL and testbench
===========================================

// Module: binary_to_decimal_serial
// PURPOSE
//  Iterative double-dabble converter: turns an unsigned binary value into packed BCD digits.
//  Sits downstream of the square-root datapath: consumes root[7:0] and feeds the nibbles
//  of the seven_segment_display.
//  Handshake is start/busy/done, so the display sees only completed results.
// PARAMETERS
//  WIDTH_BINARY  8  width of the binary input; also the number of shift iterations
//  COUNT_DIGIT   3  number of BCD output digits; decimal is 4*COUNT_DIGIT bits wide
// PORTS
//  clock     in   1                 single clock; all state updates on posedge
//  reset     in   1                 asynchronous, active-low; asserts immediately, released synchronously by use
//  start     in   1                 request conversion; sampled only in IDLE
//  binary    in   WIDTH_BINARY      value to convert; captured on the accepting edge
//  busy      out  1                 high from the accepting edge until the return to IDLE
//  done      out  1                 one-cycle pulse when decimal/overflow update
//  overflow  out  1                 result needed more than COUNT_DIGIT digits
//  decimal   out  4*COUNT_DIGIT     packed BCD, digit 0 in [3:0]; holds the last result
// BEHAVIOUR
//  Reset (reset==0):
//   state=IDLE; busy=0, done=0, overflow=0, decimal=0.
//   Scratch shift register and iteration counter cleared.
//  States: IDLE -> SHIFT -> FINISH -> IDLE.
//  IDLE:
//   - start==1: latch binary into the shift register; clear the BCD scratch; counter=WIDTH_BINARY; go to SHIFT.
//   - start==0: remain in IDLE.
//  SHIFT, one step per cycle:
//   - every scratch nibble >=5 gets +3 (4-bit add, no carry across nibbles);
//   - then {scratch, shiftreg} is shifted left by 1;
//   - counter decrements; at counter==1 the step completes and state goes to FINISH.
//  Scratch is 4*COUNT_DIGIT+1 bits wide; the extra top bit captures overflow.
//  FINISH:
//   - decimal <= scratch[4*COUNT_DIGIT-1:0];
//   - overflow <= scratch top bit, OR any bit shifted out beyond it;
//   - done=1 for exactly this cycle; next state IDLE.
//  Latency: start accepted at edge N -> done high in cycle N+WIDTH_BINARY+1.
//   With defaults: 9 cycles, then busy falls.
//  busy is high in SHIFT and FINISH. start in those states is ignored; it is not queued.
//  start held high: a new conversion is accepted on the first IDLE edge after FINISH.
//   Back-to-back throughput is therefore WIDTH_BINARY+2 cycles.
//  binary changing after acceptance has no effect on the running conversion.
//  decimal and overflow change only in FINISH and are stable between done pulses.
//  Reset mid-conversion: abort at once, all outputs to reset values, no done pulse.
//  Outputs are registered; there is no combinational path from start to busy or done.
// STRUCTURE
//  Shared package:
//   - state encoding constants STATE_IDLE=2'b00, STATE_SHIFT=2'b01, STATE_FINISH=2'b10;
//   - localparam WIDTH_DECIMAL = 4*COUNT_DIGIT;
//   - counter width = $clog2(WIDTH_BINARY+1).
//  Sub-module bcd_adjust_digit:
//   - combinational; in [3:0] -> out [3:0], out = (in>=5) ? in+3 : in;
//   - instantiated COUNT_DIGIT times via generate.
//  FSM and datapath sit in one always block per clocked register group.
//   Next-state logic is a separate always @(*) with a default assignment for every signal.
// TESTING
//  - binary=8'd0, start pulse -> done at cycle 9, decimal=12'h000, overflow=0.
//  - binary=8'd255 -> decimal=12'h255, overflow=0; binary=8'd99 -> 12'h099; 8'd10 -> 12'h010.
//  - Sweep all 256 inputs with start held high -> every done shows correct BCD, and done pulses are 10 cycles apart.
//  - start pulses during SHIFT with a different binary -> ignored; the result matches the first value and busy never drops early.
//  - reset low at SHIFT cycle 4 -> busy=0, decimal=0 immediately, no done; the next start converts normally.
//  - COUNT_DIGIT=2, binary=8'd200 -> overflow=1, decimal=8'h00; binary=8'd99 -> overflow=0, decimal=8'h99.

Source files
------------

// File: rtl/binary_to_decimal_serial_pkg.sv
// Shared definitions for the serial binary-to-BCD converter.
//   state_t          : converter FSM state encoding
//   DEFAULT_*        : default sizing used by the top-level parameters
//   decimal_width()  : packed BCD width for a given digit count
//   counter_width()  : iteration counter width for a given binary width
package binary_to_decimal_serial_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'b00,
    STATE_SHIFT  = 2'b01,
    STATE_FINISH = 2'b10
  } state_t;

  localparam int unsigned DEFAULT_WIDTH_BINARY = 8;
  localparam int unsigned DEFAULT_COUNT_DIGIT  = 3;

  function automatic int unsigned decimal_width(input int unsigned count_digit);
    return 4 * count_digit;
  endfunction

  function automatic int unsigned counter_width(input int unsigned width_binary);
    return $clog2(width_binary + 1);
  endfunction

endpackage

// File: rtl/binary_to_decimal_serial_bcd_adjust_digit.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
//   digit_i [3:0] : scratch nibble before the shift
//   digit_o [3:0] : corrected nibble (4-bit add, no carry out)
module bcd_adjust_digit
  import binary_to_decimal_serial_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/binary_to_decimal_serial.sv
// Iterative double-dabble converter: unsigned binary in, packed BCD out.
// One shift step per cycle; start/busy/done handshake so consumers only see
// completed results.
//   clock    : single clock, posedge
//   reset    : asynchronous, active-low
//   start    : conversion request, sampled only in IDLE
//   binary   : value to convert, captured on the accepting edge
//   busy     : high from the accepting edge until the return to IDLE
//   done     : one-cycle pulse while decimal/overflow present a new result
//   overflow : result needed more than COUNT_DIGIT digits
//   decimal  : packed BCD, digit 0 in [3:0]; holds the last result
module binary_to_decimal_serial
  import binary_to_decimal_serial_pkg::*;
#(
  parameter int unsigned WIDTH_BINARY = DEFAULT_WIDTH_BINARY,
  parameter int unsigned COUNT_DIGIT  = DEFAULT_COUNT_DIGIT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WIDTH_BINARY-1:0]  binary,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [4*COUNT_DIGIT-1:0] decimal
);

  localparam int unsigned WIDTH_DECIMAL = decimal_width(COUNT_DIGIT);
  localparam int unsigned WIDTH_COUNT   = counter_width(WIDTH_BINARY);

  state_t                    state_q, state_d;
  logic [WIDTH_BINARY-1:0]   shift_q, shift_d;
  logic [WIDTH_DECIMAL:0]    scratch_q, scratch_d;
  logic                      sticky_q, sticky_d;
  logic [WIDTH_COUNT-1:0]    count_q, count_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      overflow_q, overflow_d;
  logic [WIDTH_DECIMAL-1:0]  decimal_q, decimal_d;

  logic [WIDTH_DECIMAL-1:0]              adjusted;
  logic [WIDTH_DECIMAL+WIDTH_BINARY:0]   joined;
  logic [WIDTH_DECIMAL+WIDTH_BINARY:0]   shifted;

  for (genvar g = 0; g < COUNT_DIGIT; g++) begin : g_digit
    bcd_adjust_digit u_adjust (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (adjusted[4*g +: 4])
    );
  end

  // The spare top scratch bit is not a digit and is never corrected.
  assign joined  = {scratch_q[WIDTH_DECIMAL], adjusted, shift_q};
  assign shifted = {joined[WIDTH_DECIMAL+WIDTH_BINARY-1:0], 1'b0};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    sticky_d   = sticky_q;
    count_d    = count_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    decimal_d  = decimal_q;
    case (state_q)
      STATE_IDLE: begin
        if (start) begin
          shift_d   = binary;
          scratch_d = '0;
          sticky_d  = 1'b0;
          count_d   = WIDTH_COUNT'(WIDTH_BINARY);
          busy_d    = 1'b1;
          state_d   = STATE_SHIFT;
        end
      end
      STATE_SHIFT: begin
        scratch_d = shifted[WIDTH_DECIMAL+WIDTH_BINARY:WIDTH_BINARY];
        shift_d   = shifted[WIDTH_BINARY-1:0];
        // Anything pushed past the spare bit still means overflow.
        sticky_d  = sticky_q | joined[WIDTH_DECIMAL+WIDTH_BINARY];
        count_d   = count_q - WIDTH_COUNT'(1);
        if (count_q == WIDTH_COUNT'(1)) begin
          // Result registers load on the edge entering FINISH so that
          // decimal/overflow are valid in the same cycle done is high.
          decimal_d  = scratch_d[WIDTH_DECIMAL-1:0];
          overflow_d = scratch_d[WIDTH_DECIMAL] | sticky_d;
          done_d     = 1'b1;
          state_d    = STATE_FINISH;
        end
      end
      STATE_FINISH: begin
        busy_d  = 1'b0;
        state_d = STATE_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= STATE_IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      sticky_q   <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      decimal_q  <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      decimal_q  <= decimal_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign decimal  = decimal_q;

endmodule

// File: tb/tb_binary_to_decimal_serial.sv
// Scoreboard bench for binary_to_decimal_serial: default 3-digit instance plus
// a 2-digit instance for overflow behaviour.
module tb_binary_to_decimal_serial;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, start2;
  logic [7:0]  binary, binary2;
  logic        busy, done, overflow;
  logic [11:0] decimal;
  logic        busy2, done2, overflow2;
  logic [7:0]  decimal2;

  binary_to_decimal_serial #(.WIDTH_BINARY(8), .COUNT_DIGIT(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .binary   (binary),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .decimal  (decimal)
  );

  binary_to_decimal_serial #(.WIDTH_BINARY(8), .COUNT_DIGIT(2)) dut2 (
    .clock    (clock),
    .reset    (reset),
    .start    (start2),
    .binary   (binary2),
    .busy     (busy2),
    .done     (done2),
    .overflow (overflow2),
    .decimal  (decimal2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] dec;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [11:0] bcd3(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Monitor: pops the scoreboard on each done, checks latency, pulse width,
  // spacing during the sweep and stability of results between pulses.
  logic        done_prev = 1'b0;
  int          last_done = -1;
  bit          sweeping  = 1'b0;
  logic [11:0] held_dec  = '0;
  logic        held_ov   = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      held_dec  = '0;
      held_ov   = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (done) begin
        check("done_width", 32'(done_prev), 0);
        check("busy_at_done", 32'(busy), 1);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 0);
        end else begin
          mon_e = sb.pop_front();
          check("decimal", 32'(decimal), 32'(mon_e.dec));
          check("overflow", 32'(overflow), 32'(mon_e.ov));
          check("latency", cyc - mon_e.acc, 8);
        end
        if (sweeping && last_done >= 0) check("done_spacing", cyc - last_done, 10);
        last_done = cyc;
        held_dec  = decimal;
        held_ov   = overflow;
      end else begin
        check("decimal_stable", 32'(decimal), 32'(held_dec));
        check("overflow_stable", 32'(overflow), 32'(held_ov));
      end
      done_prev = done;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic convert(input int v, input bit expect_done);
    @(negedge clock);
    wait_idle();
    start  = 1'b1;
    binary = 8'(v);
    if (expect_done) sb.push_back('{bcd3(v), 1'b0, cyc + 1});
    @(negedge clock);
    start  = 1'b0;
    binary = 8'($urandom);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic convert2(input int v);
    int n = 0;
    @(negedge clock);
    while (busy2 && n < 100) begin
      @(negedge clock);
      n++;
    end
    start2  = 1'b1;
    binary2 = 8'(v);
    @(negedge clock);
    start2  = 1'b0;
    binary2 = 8'($urandom);
    n = 0;
    while (!done2 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("d2_done_timeout", 32'(done2), 1);
    check("d2_decimal", 32'(decimal2), 32'(bcd2(v)));
    check("d2_overflow", 32'(overflow2), 32'(v >= 100));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    start2  = 1'b0;
    binary  = '0;
    binary2 = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_decimal", 32'(decimal), 0);
    reset = 1'b1;

    // Directed values.
    convert(0, 1'b1);   drain(30);
    convert(255, 1'b1); drain(30);
    convert(99, 1'b1);  drain(30);
    convert(10, 1'b1);  drain(30);

    // Start pulses with a different value while shifting are ignored.
    convert(123, 1'b1);
    for (int i = 0; i < 4; i++) begin
      start  = 1'b1;
      binary = 8'd77;
      check("busy_hold", 32'(busy), 1);
      @(negedge clock);
    end
    start = 1'b0;
    drain(30);

    // Reset in the middle of SHIFT aborts with no done pulse.
    convert(42, 1'b0);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_decimal", 32'(decimal), 0);
    check("abort_done", 32'(done), 0);
    check("abort_overflow", 32'(overflow), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (15) @(negedge clock);
    check("abort_idle", 32'(busy), 0);
    convert(58, 1'b1); drain(30);

    // Full sweep with start held high; binary is scrambled after acceptance.
    @(negedge clock);
    wait_idle();
    sweeping  = 1'b1;
    last_done = -1;
    for (int v = 0; v < 256; v++) begin
      start  = 1'b1;
      binary = 8'(v);
      sb.push_back('{bcd3(v), 1'b0, cyc + 1});
      @(negedge clock);
      binary = 8'($urandom);
      repeat (9) @(negedge clock);
    end
    start = 1'b0;
    drain(40);
    sweeping = 1'b0;

    // Two-digit instance: overflow boundary.
    convert2(200);
    convert2(99);
    convert2(100);
    convert2(0);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
